spike_dispatcher: RTL and testbench

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

---
 rtl/accel_pkg.sv | 20 ++
 rtl/spike_priority_enc.sv | 22 ++
 rtl/spike_dispatcher.sv | 111 +++++++++++
 tb/tb_spike_dispatcher.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the spike-routing accelerator: address width, the
// null address driven between events, and the dispatcher state encoding.
package accel_pkg;

  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] NULL_ADDRESS = 12'hFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // Neuron index to global source address; wraps modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] neuron_address(
    input logic [ADDR_W-1:0] base,
    input logic [6:0]        index
  );
    return base + ADDR_W'(index);
  endfunction

endpackage

// File: rtl/spike_priority_enc.sv
// Combinational lowest-set-bit finder: index of the lowest set bit of vec,
// with any_set flagging a nonzero vector (index is 0 when vec is zero).
module spike_priority_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any_set
);

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    index   = '0;
    any_set = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Serialises a captured per-neuron spike vector into source addresses for the
// MAC units, lowest neuron first, then strobes clear_out to end the timestep.
module spike_dispatcher
  import accel_pkg::*;
#(
  parameter int                NUM_NEURONS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = 12'd3,
  parameter int                CLEAR_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   spike_valid,
  output logic                   capture_ready,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   address_valid,
  input  logic                   address_ready,
  output logic                   clear_out,
  output logic [7:0]             overflow_count
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDRESS = ADDR_W'(BASE_ADDRESS + NUM_NEURONS - 1);

  if (NUM_NEURONS < 1 || NUM_NEURONS > 64) begin : g_bad_num_neurons
    $error("spike_dispatcher: NUM_NEURONS must be 1..64");
  end
  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_bad_clear_cycles
    $error("spike_dispatcher: CLEAR_CYCLES must be 1..15");
  end
  // The top neuron must never alias the null address seen between events.
  if (LAST_ADDRESS == NULL_ADDRESS) begin : g_bad_address_range
    $error("spike_dispatcher: BASE_ADDRESS+NUM_NEURONS-1 collides with NULL_ADDRESS");
  end

  logic [1:0]             state, state_nxt;
  logic [NUM_NEURONS-1:0] pending, pending_nxt;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   any_nxt;
  logic [3:0]             clear_cnt;
  logic                   capture, transfer, last_clear, offer_nxt;

  assign capture    = spike_valid & capture_ready;
  assign transfer   = address_valid & address_ready;
  assign last_clear = (clear_cnt == 4'(CLEAR_CYCLES - 1));

  // Outputs are registered, so they are computed from the pending vector as it
  // will be after this edge; that gives the one-cycle capture-to-address latency.
  always_comb begin
    pending_nxt = pending;
    case (state)
      ST_IDLE: if (capture) pending_nxt = spike_in;
      // The offered address is always the lowest set bit, so dropping the
      // lowest set bit retires exactly the transferred neuron.
      ST_SCAN: if (transfer) pending_nxt = pending & (pending - NUM_NEURONS'(1));
      ST_CLEAR: pending_nxt = '0;
      default:  pending_nxt = '0;
    endcase
  end

  spike_priority_enc #(
    .WIDTH (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_priority_enc (
    .vec     (pending_nxt),
    .index   (idx_nxt),
    .any_set (any_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (capture) state_nxt = ST_SCAN;
      ST_SCAN:  if (!any_nxt) state_nxt = ST_CLEAR;
      ST_CLEAR: if (last_clear) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign offer_nxt = (state_nxt == ST_SCAN) & any_nxt;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  // NOTE: pending is control state (it decides whether a timestep is still in
  // flight), so it is reset along with the FSM; abandoning a timestep on reset
  // depends on it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      pending        <= '0;
      clear_cnt      <= '0;
      capture_ready  <= 1'b1;
      address_valid  <= 1'b0;
      source_address <= NULL_ADDRESS;
      clear_out      <= 1'b0;
      overflow_count <= '0;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      clear_cnt      <= (state == ST_CLEAR && !last_clear) ? clear_cnt + 4'd1 : 4'd0;
      capture_ready  <= (state_nxt == ST_IDLE);
      address_valid  <= offer_nxt;
      source_address <= offer_nxt ? neuron_address(BASE_ADDRESS, 7'(idx_nxt)) : NULL_ADDRESS;
      clear_out      <= (state_nxt == ST_CLEAR);
      if (spike_valid && !capture_ready && overflow_count != 8'hFF) begin
        overflow_count <= overflow_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Self-checking bench for spike_dispatcher: a queue-based timestep model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_spike_dispatcher;

  localparam int               NUM     = 16;
  localparam logic [11:0]      BASE    = 12'd3;
  localparam int               CLR     = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [NUM-1:0]  spike_in;
  logic            spike_valid;
  logic            capture_ready;
  logic [11:0]     source_address;
  logic            address_valid;
  logic            address_ready;
  logic            clear_out;
  logic [7:0]      overflow_count;

  int checks   = 0;
  int failures = 0;

  spike_dispatcher #(
    .NUM_NEURONS  (NUM),
    .BASE_ADDRESS (BASE),
    .CLEAR_CYCLES (CLR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .spike_in       (spike_in),
    .spike_valid    (spike_valid),
    .capture_ready  (capture_ready),
    .source_address (source_address),
    .address_valid  (address_valid),
    .address_ready  (address_ready),
    .clear_out      (clear_out),
    .overflow_count (overflow_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Timestep model: a queue of addresses still to deliver, a scanning flag and
  // a count of clear cycles left. Idle means neither scanning nor clearing.
  bit          m_started = 1'b0;
  bit          m_scan    = 1'b0;
  int          m_clear_left = 0;
  int          m_ovf     = 0;
  logic [11:0] m_q[$];

  always @(posedge clock) begin
    bit idle;
    m_started = 1'b1;
    if (reset) begin
      m_q.delete();
      m_scan       = 1'b0;
      m_clear_left = 0;
      m_ovf        = 0;
    end else begin
      idle = !m_scan && m_clear_left == 0;
      if (!idle && spike_valid && m_ovf < 255) m_ovf++;
      if (idle) begin
        if (spike_valid) begin
          m_q.delete();
          for (int i = 0; i < NUM; i++) if (spike_in[i]) m_q.push_back(12'(BASE + i));
          m_scan = 1'b1;
        end
      end else if (m_scan) begin
        if (m_q.size() > 0 && address_ready) void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_scan       = 1'b0;
          m_clear_left = CLR;
        end
      end else begin
        m_clear_left--;
      end
    end
  end

  always @(negedge clock) begin
    bit          e_idle, e_valid;
    logic [11:0] e_addr;
    if (m_started) begin
      e_idle  = !m_scan && m_clear_left == 0;
      e_valid = m_scan && m_q.size() > 0;
      e_addr  = e_valid ? m_q[0] : 12'hFFF;
      check("model_capture_ready", 32'(capture_ready), 32'(e_idle));
      check("model_address_valid", 32'(address_valid), 32'(e_valid));
      check("model_source_address", 32'(source_address), 32'(e_addr));
      check("model_clear_out", 32'(clear_out), 32'(m_clear_left > 0));
      check("model_overflow_count", 32'(overflow_count), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!capture_ready && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(capture_ready), 32'd1);
  endtask

  task automatic capture(input logic [NUM-1:0] vec);
    spike_in    = vec;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
  endtask

  initial begin
    int n_xfer, n_clr, n_cap;
    bit prev_clr;

    reset = 1'b1; spike_in = '0; spike_valid = 1'b0; address_ready = 1'b1;
    tick(); tick();
    check("reset_capture_ready", 32'(capture_ready), 32'd1);
    check("reset_source_address", 32'(source_address), 32'hFFF);
    check("reset_clear_out", 32'(clear_out), 32'd0);
    reset = 1'b0;
    tick();

    // Three spikes, MAC always ready: 3, 5, 8 back to back, then 2 clear cycles.
    capture(16'h0025);
    check("t1_addr0", 32'(source_address), 32'd3);
    tick(); check("t1_addr1", 32'(source_address), 32'd5);
    tick(); check("t1_addr2", 32'(source_address), 32'd8);
    tick(); check("t1_clear0", 32'(clear_out), 32'd1);
    check("t1_null_addr", 32'(source_address), 32'hFFF);
    check("t1_not_ready", 32'(capture_ready), 32'd0);
    tick(); check("t1_clear1", 32'(clear_out), 32'd1);
    tick(); check("t1_clear_end", 32'(clear_out), 32'd0);
    check("t1_ready_again", 32'(capture_ready), 32'd1);

    // Empty timestep: no address, clear starts two cycles after capture.
    capture(16'h0000);
    check("t2_no_valid", 32'(address_valid), 32'd0);
    check("t2_no_clear_yet", 32'(clear_out), 32'd0);
    tick(); check("t2_clear0", 32'(clear_out), 32'd1);
    tick(); check("t2_clear1", 32'(clear_out), 32'd1);
    tick(); check("t2_ready_again", 32'(capture_ready), 32'd1);

    // Back-pressure: address 3 held for five cycles, then 7.
    check("t3_null_before", 32'(source_address), 32'hFFF);
    address_ready = 1'b0;
    capture(16'h0011);
    for (int k = 1; k <= 5; k++) begin
      check("t3_hold_addr", 32'(source_address), 32'd3);
      check("t3_hold_valid", 32'(address_valid), 32'd1);
      if (k == 5) address_ready = 1'b1;
      else tick();
    end
    tick(); check("t3_second_addr", 32'(source_address), 32'd7);
    tick(); check("t3_null_after", 32'(source_address), 32'hFFF);
    wait_idle();

    // Overflow saturation while stalled, then all 16 addresses drain in order.
    address_ready = 1'b0;
    capture(16'hFFFF);
    for (int p = 0; p < 300; p++) begin
      spike_valid = 1'b1; tick();
      spike_valid = 1'b0; tick();
    end
    check("t4_overflow_sat", 32'(overflow_count), 32'd255);
    check("t4_still_first", 32'(source_address), 32'd3);
    address_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t4_drain_addr", 32'(source_address), 32'(3 + i));
      tick();
    end
    check("t4_drained", 32'(address_valid), 32'd0);
    wait_idle();

    // Reset after two of four transfers abandons the timestep.
    capture(16'h000F);
    tick(); tick();
    check("t5_third_addr", 32'(source_address), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_ready", 32'(capture_ready), 32'd1);
    check("t5_rst_valid", 32'(address_valid), 32'd0);
    check("t5_rst_addr", 32'(source_address), 32'hFFF);
    check("t5_rst_ovf", 32'(overflow_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); check("t5_no_clear", 32'(clear_out), 32'd0);
    end
    capture(16'h0001);
    check("t5_recapture_addr", 32'(source_address), 32'd3);
    wait_idle();

    // spike_valid held high: one address 4 and one clear per timestep.
    n_xfer = 0; n_clr = 0; n_cap = 0; prev_clr = 1'b0;
    spike_in = 16'h0002; spike_valid = 1'b1; address_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (address_valid) begin
        n_xfer++;
        check("t6_addr", 32'(source_address), 32'd4);
      end
      if (clear_out && !prev_clr) n_clr++;
      prev_clr = clear_out;
      if (capture_ready && spike_valid) n_cap++;
    end
    spike_valid = 1'b0;
    check("t6_transfers", 32'(n_xfer), 32'd5);
    check("t6_clears", 32'(n_clr), 32'd5);
    check("t6_captures", 32'(n_cap), 32'd5);
    tick(); check("t6_idle", 32'(capture_ready), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
